// File: rtl/tcm_bus_resp_pkg.sv
// Shared femto bus definitions for the TCM responder: bus widths, access sizes,
// FSM encoding and byte-lane helpers.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif
`ifndef TCM_BASE
`define TCM_BASE 32'h0000_0000
`endif
`ifndef TCM_SIZE
`define TCM_SIZE 1024
`endif

package tcm_bus_resp_pkg;
  localparam int XLEN      = `XLEN;
  localparam int BUS_WIDTH = `BUS_WIDTH;
  localparam int BUS_BYTES = BUS_WIDTH / 8;
  localparam int ACC_W     = $clog2(`BUS_ACC_CNT);
  localparam int TCM_SIZE  = `TCM_SIZE;
  localparam logic [XLEN-1:0] TCM_BASE = `TCM_BASE;

  localparam logic [ACC_W-1:0] ACC_BYTE = ACC_W'(0);
  localparam logic [ACC_W-1:0] ACC_HALF = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_WORD = ACC_W'(2);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  function automatic logic is_misaligned(input logic [ACC_W-1:0] acc, input logic [1:0] off);
    case (acc)
      ACC_BYTE: return 1'b0;
      ACC_HALF: return off[0];
      ACC_WORD: return off != 2'd0;
      default:  return 1'b1;
    endcase
  endfunction

  function automatic logic [BUS_BYTES-1:0] acc_be(input logic [ACC_W-1:0] acc, input logic [1:0] off);
    logic [BUS_BYTES-1:0] m;
    case (acc)
      ACC_BYTE: m = BUS_BYTES'(4'b0001);
      ACC_HALF: m = BUS_BYTES'(4'b0011);
      default:  m = BUS_BYTES'(4'b1111);
    endcase
    return BUS_BYTES'(m << off);
  endfunction

  function automatic logic [BUS_WIDTH-1:0] lane_shift(input logic [BUS_WIDTH-1:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  // Inverse of lane_shift for reads: right-align, then zero everything above the access width.
  function automatic logic [BUS_WIDTH-1:0] rd_extract(input logic [BUS_WIDTH-1:0] w,
                                                       input logic [ACC_W-1:0] acc, input logic [1:0] off);
    logic [BUS_WIDTH-1:0] s;
    s = w >> {off, 3'b000};
    case (acc)
      ACC_BYTE: return {{(BUS_WIDTH-8){1'b0}}, s[7:0]};
      ACC_HALF: return {{(BUS_WIDTH-16){1'b0}}, s[15:0]};
      default:  return s;
    endcase
  endfunction
endpackage

// File: rtl/tcm_bus_resp_ram.sv
// Single-port word RAM, per-byte write enables, one-cycle synchronous read.
// No reset on the array or read register so the tools can map it onto block RAM.
module tcm_bus_resp_ram
  import tcm_bus_resp_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic [AW-1:0]        addr_i,
  input  logic                 we_i,
  input  logic [BUS_BYTES-1:0] be_i,
  input  logic [BUS_WIDTH-1:0] wdata_i,
  input  logic                 re_i,
  output logic [BUS_WIDTH-1:0] rdata_o
);
  logic [BUS_WIDTH-1:0] mem_q [2**AW];
  logic [BUS_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BUS_BYTES; b++)
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/tcm_bus_resp.sv
// femto data-bus responder backed by a word RAM, with programmable wait states.
// Optional address range checking is enabled by defining TCM_BUS_RESP_RANGE_CHECK_EN.
module tcm_bus_resp
  import tcm_bus_resp_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE        = TCM_BASE,
  parameter int              SPAN        = $clog2(TCM_SIZE),
  parameter int              WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_req,
  input  logic [XLEN-1:0]      s_addr,
  input  logic                 s_w_rb,
  input  logic [ACC_W-1:0]     s_acc,
  input  logic [BUS_WIDTH-1:0] s_wdata,
  output logic                 s_resp,
  output logic [BUS_WIDTH-1:0] s_rdata,
  output logic                 misalign,
`ifdef TCM_BUS_RESP_RANGE_CHECK_EN
  output logic                 range_err,
`endif
  output logic                 proto_err
);
  localparam int AW = SPAN - 2;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 perr_q, perr_d;
  logic                 cap;
  logic [SPAN-1:0]      addr_q;
  logic                 w_rb_q;
  logic [ACC_W-1:0]     acc_q;
  logic [BUS_WIDTH-1:0] wdata_q, rdata_q, rdata_d, ram_rdata;
  logic                 rng_q, mis, in_resp, ram_re, ram_we;
  logic [AW-1:0]        ram_addr;
  logic                 unused;

`ifdef TCM_BUS_RESP_RANGE_CHECK_EN
  localparam logic [XLEN-1:0] MASK = XLEN'((64'd1 << SPAN) - 64'd1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)    rng_q <= 1'b0;
    else if (cap) rng_q <= (s_addr & ~MASK) != BASE;
  assign range_err = in_resp & rng_q;
  assign unused    = 1'b0;
`else
  assign rng_q  = 1'b0;
  assign unused = ^{s_addr[XLEN-1:SPAN], BASE};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      w_rb_q  <= 1'b0;
      acc_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
      rdata_q <= rdata_d;
      if (cap) begin
        addr_q  <= s_addr[SPAN-1:0];
        w_rb_q  <= s_w_rb;
        acc_q   <= s_acc;
        wdata_q <= s_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: if (s_req) begin
        cap = 1'b1;
        if (WAIT_CYCLES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
        if (s_req) perr_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        if (s_req) perr_d = 1'b1;
      end
    endcase
  end

  assign in_resp = state_q == ST_RESP;
  assign mis     = is_misaligned(acc_q, addr_q[1:0]);

  // The RAM read is issued on the cycle that moves into RESP; with no wait states
  // that is the capture cycle itself, so the address comes straight off the bus.
  assign ram_re   = (state_d == ST_RESP) && !in_resp;
  assign ram_we   = in_resp && w_rb_q && !mis && !rng_q;
  assign ram_addr = (state_q == ST_IDLE) ? s_addr[SPAN-1:2] : addr_q[SPAN-1:2];

  tcm_bus_resp_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (acc_be(acc_q, addr_q[1:0])),
    .wdata_i (lane_shift(wdata_q, addr_q[1:0])),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rdata_d = rdata_q;
    if (in_resp)
      rdata_d = (w_rb_q || mis || rng_q) ? '0 : rd_extract(ram_rdata, acc_q, addr_q[1:0]);
  end

  assign s_resp    = in_resp;
  assign s_rdata   = rdata_d;
  assign misalign  = in_resp & mis;
  assign proto_err = perr_q;
endmodule

// File: tb/tb_tcm_bus_resp.sv
// Randomised self-checking bench for tcm_bus_resp: two instances (0 and 3 wait
// states) checked against a byte-addressed reference memory.
module tb_tcm_bus_resp;
  import tcm_bus_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req3, w_rb;
  logic [1:0]  acc;
  logic [31:0] addr, wdata;
  logic        resp0, resp3, mis0, mis3, perr0, perr3;
  logic [31:0] rdata0, rdata3;
`ifdef TCM_BUS_RESP_RANGE_CHECK_EN
  logic        rerr0, rerr3;
`endif

  always #5 clk = ~clk;

  tcm_bus_resp #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .s_req(req0), .s_addr(addr), .s_w_rb(w_rb), .s_acc(acc),
    .s_wdata(wdata), .s_resp(resp0), .s_rdata(rdata0), .misalign(mis0),
`ifdef TCM_BUS_RESP_RANGE_CHECK_EN
    .range_err(rerr0),
`endif
    .proto_err(perr0));

  tcm_bus_resp #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .s_req(req3), .s_addr(addr), .s_w_rb(w_rb), .s_acc(acc),
    .s_wdata(wdata), .s_resp(resp3), .s_rdata(rdata3), .misalign(mis3),
`ifdef TCM_BUS_RESP_RANGE_CHECK_EN
    .range_err(rerr3),
`endif
    .proto_err(perr3));

  logic [7:0] mem [2][64];
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int d);
    return d ? rdata3 : rdata0;
  endfunction
  function automatic logic rsp(input int d);
    return d ? resp3 : resp0;
  endfunction
  function automatic logic msa(input int d);
    return d ? mis3 : mis0;
  endfunction

  // inj_at >= 0 throws a junk write request at the DUT that many cycles into the wait.
  task automatic txn(input int d, input bit w, input logic [1:0] a_acc, input logic [31:0] a,
                     input logic [31:0] wd, input int inj_at = -1);
    int sz, lo, n;
    bit bad, rng;
    logic [31:0] exp_rd;
    sz  = (a_acc == 2'd0) ? 1 : (a_acc == 2'd1) ? 2 : 4;
    bad = (a_acc == 2'd3) || ((a % sz) != 0);
    rng = 1'b0;
`ifdef TCM_BUS_RESP_RANGE_CHECK_EN
    rng = (a & ~32'(TCM_SIZE - 1)) != TCM_BASE;
`endif
    lo     = int'(a & 32'd63);
    exp_rd = '0;
    if (!bad && !rng) begin
      for (int k = 0; k < sz; k++)
        if (w) mem[d][lo+k] = wd[8*k +: 8];
        else   exp_rd[8*k +: 8] = mem[d][lo+k];
    end
    @(negedge clk);
    addr = a; w_rb = w; acc = a_acc; wdata = wd;
    if (d == 0) req0 = 1'b1; else req3 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; req3 = 1'b0;
    n = 0;
    while (!rsp(d) && n < 20) begin
      if (n == inj_at) begin
        req3 = 1'b1; addr = 32'h14 | TCM_BASE; w_rb = 1'b1; acc = 2'd2; wdata = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      req3 = 1'b0;
      n++;
    end
    chk($sformatf("lat%0d", d), n, d ? 3 : 0);
    chk($sformatf("mis%0d", d), 32'(msa(d)), 32'(bad));
    if (!w) chk($sformatf("rdata%0d @%h", d, a), rd(d), exp_rd);
`ifdef TCM_BUS_RESP_RANGE_CHECK_EN
    chk($sformatf("rerr%0d", d), 32'(d ? rerr3 : rerr0), 32'(rng));
`endif
    @(negedge clk);
    chk($sformatf("resp_pulse%0d", d), 32'(rsp(d)), 32'd0);
    if (!w) chk($sformatf("rdata_hold%0d", d), rd(d), exp_rd);
  endtask

  task automatic chk_reset_vals();
    chk("rst_resp0", 32'(resp0), 0);  chk("rst_resp3", 32'(resp3), 0);
    chk("rst_rdata0", rdata0, 0);     chk("rst_rdata3", rdata3, 0);
    chk("rst_mis0", 32'(mis0), 0);    chk("rst_mis3", 32'(mis3), 0);
    chk("rst_perr0", 32'(perr0), 0);  chk("rst_perr3", 32'(perr3), 0);
  endtask

  initial begin
    int seen;
    logic [31:0] ra;
    rstn = 1'b0; req0 = 1'b0; req3 = 1'b0; w_rb = 1'b0; acc = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rstn = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) txn(d, 1'b1, 2'd2, TCM_BASE | 32'(4*i), $urandom);

    txn(0, 1'b1, 2'd2, TCM_BASE, 32'hDEADBEEF);
    txn(0, 1'b0, 2'd2, TCM_BASE, 32'h0);
    chk("plan_word", rdata0, 32'hDEADBEEF);
    txn(0, 1'b1, 2'd0, TCM_BASE | 32'h3, 32'h0000005A);
    txn(0, 1'b0, 2'd2, TCM_BASE, 32'h0);
    chk("plan_byte", rdata0, 32'h5AADBEEF);
    txn(0, 1'b0, 2'd1, TCM_BASE | 32'h2, 32'h0);
    chk("plan_half", rdata0, 32'h00005AAD);
    txn(0, 1'b0, 2'd2, TCM_BASE | 32'h2, 32'h0);
    chk("plan_mis_rd", rdata0, 32'h0);
    txn(0, 1'b1, 2'd2, TCM_BASE | 32'h1, 32'hFFFF_FFFF);
    txn(0, 1'b0, 2'd2, TCM_BASE, 32'h0);
    chk("plan_mis_wr", rdata0, 32'h5AADBEEF);
`ifdef TCM_BUS_RESP_RANGE_CHECK_EN
    txn(0, 1'b0, 2'd2, TCM_BASE + 32'(TCM_SIZE), 32'h0);
`endif

    for (int i = 0; i < 300; i++) begin
      ra = (($urandom_range(0, 7) == 0) ? ($urandom & ~32'(TCM_SIZE - 1)) : TCM_BASE) | ($urandom & 32'd63);
      txn(i % 2, 1'($urandom), 2'($urandom), ra, $urandom);
    end

    chk("perr_clean", 32'(perr3), 0);
    txn(1, 1'b1, 2'd2, TCM_BASE | 32'h8, 32'hCAFEF00D, 1);
    chk("perr_set", 32'(perr3), 1);
    chk("perr_other", 32'(perr0), 0);
    txn(1, 1'b0, 2'd2, TCM_BASE | 32'h14, 32'h0);
    txn(1, 1'b0, 2'd2, TCM_BASE | 32'h8, 32'h0);
    chk("perr_sticky", 32'(perr3), 1);

    // Write aborted by reset while waiting: must never respond nor land in memory.
    @(negedge clk);
    addr = TCM_BASE | 32'h8; w_rb = 1'b1; acc = 2'd2; wdata = 32'h11223344; req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    rstn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp3) seen++;
    end
    chk("abort_no_resp", 32'(seen), 0);
    txn(1, 1'b0, 2'd2, TCM_BASE | 32'h8, 32'h0);
    txn(1, 1'b0, 2'd0, TCM_BASE | 32'hB, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
